// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants, receiver FSM encoding and a width helper
//                for the buffered UART receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Number of bits needed to index 'value' distinct items (ceil(log2)).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with first-word fall-through output,
//                registered pointers and occupancy/empty/full flags.
//                A push into a full FIFO is accepted only when a pop happens
//                in the same cycle; a pop on an empty FIFO is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        pop_data,
    output logic                    empty,
    output logic                    full,
    output logic [clog2(DEPTH):0]   count
);

    localparam int c_AW = clog2(DEPTH);
    localparam logic [c_AW:0] c_ONE       = (c_AW+1)'(1);
    localparam logic [c_AW:0] c_DEPTH_CNT = (c_AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             r_empty;
    logic             r_full;
    logic [WIDTH-1:0] r_head;

    logic             w_do_pop;
    logic             w_do_push;
    logic [c_AW:0]    w_count_nxt;
    logic [c_AW-1:0]  w_rd_ptr_nxt;

    // A pop needs data; a push needs room, or a simultaneous pop freeing a slot.
    assign w_do_pop     = pop && !r_empty;
    assign w_do_push    = push && (!r_full || w_do_pop);
    assign w_rd_ptr_nxt = r_rd_ptr + 1'b1;

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        w_count_nxt = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_nxt = r_count + c_ONE;
        end else if (!w_do_push && w_do_pop) begin
            w_count_nxt = r_count - c_ONE;
        end
    end

    // Storage array; contents need no reset because validity is tracked by count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers, flags and the registered head-of-queue word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_head   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == c_DEPTH_CNT);
            // Keep the head word valid one cycle after any change of the head.
            if (w_do_pop) begin
                if (r_count == c_ONE) begin
                    if (w_do_push) begin
                        r_head <= push_data;
                    end
                end else begin
                    r_head <= r_mem[w_rd_ptr_nxt];
                end
            end else if (r_empty && w_do_push) begin
                r_head <= push_data;
            end
        end
    end

    assign pop_data = r_head;
    assign empty    = r_empty;
    assign full     = r_full;
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_rx_buffered.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_buffered
//  Description : Parametrised UART receiver (data width, parity, stop bits)
//                with mid-bit sampling, start-bit glitch rejection, sticky
//                framing/parity/overrun flags and a receive FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int DEPTH        = 16
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rxd,
    input  logic                    rd_en,
    output logic [DATA_BITS-1:0]    rd_data,
    output logic                    empty,
    output logic                    full,
    output logic [clog2(DEPTH):0]   count,
    output logic                    frame_err,
    output logic                    parity_err,
    output logic                    overrun,
    input  logic                    clr_err,
    output logic                    busy
);

    localparam int c_CW = clog2(CLKS_PER_BIT);
    localparam int c_BW = clog2(DATA_BITS + 1);
    localparam logic [c_CW-1:0] c_HALF      = c_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CW-1:0] c_FULL      = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_BW-1:0] c_LAST_DATA = c_BW'(DATA_BITS - 1);
    localparam logic [c_BW-1:0] c_LAST_STOP = c_BW'(STOP_BITS - 1);
    localparam logic            c_ODD       = (PARITY == PARITY_ODD);

    logic                  r_sync1;
    logic                  r_rxs;
    rx_state_t             r_state;
    logic [c_CW-1:0]       r_clk_cnt;
    logic [c_BW-1:0]       r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_par_err;
    logic                  r_done;
    logic                  r_break;
    logic                  r_frame_err;
    logic                  r_parity_err;
    logic                  r_overrun;

    logic                  w_mid_start;
    logic                  w_mid_bit;
    logic                  w_push;
    logic                  w_full;
    logic                  w_frame_set;
    logic                  w_parity_set;
    logic                  w_overrun_set;

    assign w_mid_start = (r_clk_cnt == c_HALF);
    assign w_mid_bit   = (r_clk_cnt == c_FULL);

    // The frame is resolved on the cycle after the last good stop sample.
    assign w_push        = (r_state == ST_STOP) && r_done && !r_par_err;
    assign w_parity_set  = (r_state == ST_STOP) && r_done && r_par_err;
    assign w_frame_set   = (r_state == ST_STOP) && !r_done && w_mid_bit && !r_rxs;
    assign w_overrun_set = w_push && w_full && !rd_en;

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_rxs   <= r_sync1;
        end
    end

    // Receive state machine: start validation, data shift, parity and stop checks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
            r_done    <= 1'b0;
            r_break   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (r_break) begin
                        // Line held low after a bad stop bit: wait for it to recover.
                        if (r_rxs) begin
                            r_break <= 1'b0;
                        end
                    end else if (!r_rxs) begin
                        r_state   <= ST_START;
                        r_clk_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (w_mid_start) begin
                        if (r_rxs) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state   <= ST_DATA;
                            r_clk_cnt <= '0;
                            r_bit_cnt <= '0;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_mid_bit) begin
                        r_shift   <= {r_rxs, r_shift[DATA_BITS-1:1]};
                        r_clk_cnt <= '0;
                        if (r_bit_cnt == c_LAST_DATA) begin
                            r_bit_cnt <= '0;
                            r_par_err <= 1'b0;
                            r_state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (w_mid_bit) begin
                        r_par_err <= r_rxs ^ (^r_shift) ^ c_ODD;
                        r_clk_cnt <= '0;
                        r_state   <= ST_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_done) begin
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_mid_bit) begin
                        r_clk_cnt <= '0;
                        if (!r_rxs) begin
                            r_state <= ST_IDLE;
                            r_break <= 1'b1;
                        end else if (r_bit_cnt == c_LAST_STOP) begin
                            r_done <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a new error wins over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_frame_set) begin
                r_frame_err <= 1'b1;
            end else if (clr_err) begin
                r_frame_err <= 1'b0;
            end
            if (w_parity_set) begin
                r_parity_err <= 1'b1;
            end else if (clr_err) begin
                r_parity_err <= 1'b0;
            end
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (r_shift),
        .pop       (rd_en),
        .pop_data  (rd_data),
        .empty     (empty),
        .full      (w_full),
        .count     (count)
    );

    assign full       = w_full;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_buffered.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_buffered
//  Description : Self-checking bench for uart_rx_buffered. Three instances:
//                unit 0 default 8N1/16, unit 1 even parity, unit 2 DEPTH=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_buffered;

    localparam int BIT = 87;

    logic       clk;
    logic       reset;
    logic [2:0] rxd;
    logic [2:0] rd_en;
    logic [2:0] clr_err;

    logic [7:0] rd_data_a, rd_data_p, rd_data_d;
    logic       empty_a, empty_p, empty_d;
    logic       full_a, full_p, full_d;
    logic [4:0] count_a, count_p;
    logic [2:0] count_d;
    logic       fe_a, fe_p, fe_d;
    logic       pe_a, pe_p, pe_d;
    logic       ov_a, ov_p, ov_d;
    logic       busy_a, busy_p, busy_d;

    int errors = 0;
    int checks = 0;

    uart_rx_buffered u_dut_a (
        .clk(clk), .reset(reset), .rxd(rxd[0]), .rd_en(rd_en[0]),
        .rd_data(rd_data_a), .empty(empty_a), .full(full_a), .count(count_a),
        .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a),
        .clr_err(clr_err[0]), .busy(busy_a)
    );

    uart_rx_buffered #(.PARITY(1)) u_dut_p (
        .clk(clk), .reset(reset), .rxd(rxd[1]), .rd_en(rd_en[1]),
        .rd_data(rd_data_p), .empty(empty_p), .full(full_p), .count(count_p),
        .frame_err(fe_p), .parity_err(pe_p), .overrun(ov_p),
        .clr_err(clr_err[1]), .busy(busy_p)
    );

    uart_rx_buffered #(.DEPTH(4)) u_dut_d (
        .clk(clk), .reset(reset), .rxd(rxd[2]), .rd_en(rd_en[2]),
        .rd_data(rd_data_d), .empty(empty_d), .full(full_d), .count(count_d),
        .frame_err(fe_d), .parity_err(pe_d), .overrun(ov_d),
        .clr_err(clr_err[2]), .busy(busy_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         unit;
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       exp_push;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    typedef struct {
        logic [31:0] cnt;
        logic [31:0] rd;
        logic [31:0] fe;
        logic [31:0] pe;
        logic [31:0] ov;
        logic [31:0] em;
        logic [31:0] fu;
        logic [31:0] bz;
    } st_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic get_status(input int u, output st_t s);
        case (u)
            0: s = '{32'(count_a), 32'(rd_data_a), 32'(fe_a), 32'(pe_a), 32'(ov_a),
                     32'(empty_a), 32'(full_a), 32'(busy_a)};
            1: s = '{32'(count_p), 32'(rd_data_p), 32'(fe_p), 32'(pe_p), 32'(ov_p),
                     32'(empty_p), 32'(full_p), 32'(busy_p)};
            default: s = '{32'(count_d), 32'(rd_data_d), 32'(fe_d), 32'(pe_d), 32'(ov_d),
                           32'(empty_d), 32'(full_d), 32'(busy_d)};
        endcase
    endtask

    // One 8-bit frame; parity bit only when use_par is set. Leaves the line idle.
    task automatic send_frame(input int u, input logic [7:0] d, input bit use_par,
                              input logic par, input logic stop);
        @(negedge clk);
        rxd[u] = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd[u] = d[i];
            repeat (BIT) @(negedge clk);
        end
        if (use_par) begin
            rxd[u] = par;
            repeat (BIT) @(negedge clk);
        end
        rxd[u] = stop;
        repeat (BIT) @(negedge clk);
        rxd[u] = 1'b1;
    endtask

    task automatic pop(input int u);
        @(negedge clk);
        rd_en[u] = 1'b1;
        @(negedge clk);
        rd_en[u] = 1'b0;
    endtask

    task automatic clear(input int u);
        @(negedge clk);
        clr_err[u] = 1'b1;
        @(negedge clk);
        clr_err[u] = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        st_t s;
        get_status(0, s);
        check({tag, "_count"}, s.cnt, 0);
        check({tag, "_empty"}, s.em, 1);
        check({tag, "_full"},  s.fu, 0);
        check({tag, "_rd_data"}, s.rd, 0);
        check({tag, "_flags"}, {s.fe[0], s.pe[0], s.ov[0]}, 0);
        check({tag, "_busy"},  s.bz, 0);
    endtask

    initial begin
        st_t s;
        logic [7:0] exp_bytes [4];

        rxd = 3'b111; rd_en = '0; clr_err = '0;
        reset = 1'b1;
        //            unit data   par   stop  push  fe    pe
        vecs[0]  = '{0, 8'h35, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{0, 8'h35, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1, 8'h31, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1, 8'h31, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1, 8'h7F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        repeat (5) @(negedge clk);
        check_reset_state("in_reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_state("after_reset");

        // Table: single frames, checked then drained and cleared.
        for (int i = 0; i < NV; i++) begin
            send_frame(vecs[i].unit, vecs[i].data, vecs[i].unit == 1, vecs[i].par, vecs[i].stop);
            repeat (4) @(negedge clk);
            get_status(vecs[i].unit, s);
            check($sformatf("v%0d_count", i), s.cnt, 32'(vecs[i].exp_push));
            if (vecs[i].exp_push)
                check($sformatf("v%0d_rd_data", i), s.rd, 32'(vecs[i].data));
            check($sformatf("v%0d_frame_err", i), s.fe, 32'(vecs[i].exp_fe));
            check($sformatf("v%0d_parity_err", i), s.pe, 32'(vecs[i].exp_pe));
            check($sformatf("v%0d_overrun", i), s.ov, 0);
            check($sformatf("v%0d_busy", i), s.bz, 0);
            if (vecs[i].exp_push) pop(vecs[i].unit);
            clear(vecs[i].unit);
            get_status(vecs[i].unit, s);
            check($sformatf("v%0d_cleared", i), {s.fe[0], s.pe[0], s.ov[0], s.em[0]}, 4'b0001);
        end

        // Back-to-back command line, drained in order.
        exp_bytes[0] = 8'h35; exp_bytes[1] = 8'h37; exp_bytes[2] = 8'h38; exp_bytes[3] = 8'h0A;
        for (int i = 0; i < 4; i++) send_frame(0, exp_bytes[i], 0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        get_status(0, s);
        check("line_count", s.cnt, 4);
        for (int i = 0; i < 4; i++) begin
            get_status(0, s);
            check($sformatf("line_rd%0d", i), s.rd, 32'(exp_bytes[i]));
            pop(0);
        end
        get_status(0, s);
        check("line_empty", s.em, 1);

        // Start-bit glitch of 20 clocks is rejected.
        @(negedge clk);
        rxd[0] = 1'b0;
        repeat (10) @(negedge clk);
        get_status(0, s);
        check("glitch_busy_during", s.bz, 1);
        repeat (10) @(negedge clk);
        rxd[0] = 1'b1;
        repeat (60) @(negedge clk);
        get_status(0, s);
        check("glitch_busy_after", s.bz, 0);
        check("glitch_count", s.cnt, 0);
        check("glitch_flags", {s.fe[0], s.pe[0], s.ov[0]}, 0);

        // DEPTH=4: fifth byte overruns, contents are the first four.
        for (int i = 0; i < 5; i++) send_frame(2, 8'h11 * (i + 1), 0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        get_status(2, s);
        check("ovr_full", s.fu, 1);
        check("ovr_flag", s.ov, 1);
        check("ovr_count", s.cnt, 4);
        for (int i = 0; i < 4; i++) begin
            get_status(2, s);
            check($sformatf("ovr_rd%0d", i), s.rd, 32'(8'h11 * (i + 1)));
            pop(2);
        end
        get_status(2, s);
        check("ovr_empty", s.em, 1);
        clear(2);
        get_status(2, s);
        check("ovr_cleared", s.ov, 0);

        // DEPTH=4: pop on the push cycle of the fifth byte avoids overrun.
        for (int i = 0; i < 4; i++) send_frame(2, 8'h61 + 8'(i), 0, 1'b0, 1'b1);
        fork
            send_frame(2, 8'h65, 0, 1'b0, 1'b1);
            begin
                @(negedge clk);
                repeat (829) @(posedge clk);
                @(negedge clk);
                rd_en[2] = 1'b1;
                @(negedge clk);
                rd_en[2] = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        get_status(2, s);
        check("pp_overrun", s.ov, 0);
        check("pp_count", s.cnt, 4);
        check("pp_full", s.fu, 1);
        for (int i = 0; i < 4; i++) begin
            get_status(2, s);
            check($sformatf("pp_rd%0d", i), s.rd, 32'(8'h62 + 8'(i)));
            pop(2);
        end

        // Reset in the middle of data bit 3 of 0x34, with one byte already queued.
        send_frame(0, 8'h41, 0, 1'b0, 1'b1);
        @(negedge clk);
        rxd[0] = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rxd[0] = 1'(8'h34 >> i);
            repeat (BIT) @(negedge clk);
        end
        rxd[0] = 1'b0;
        repeat (BIT / 2) @(negedge clk);
        reset = 1'b1;
        rxd[0] = 1'b1;
        #1;
        check_reset_state("mid_reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (BIT) @(negedge clk);
        check_reset_state("post_mid_reset");
        send_frame(0, 8'h34, 0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        get_status(0, s);
        check("rst_rx_count", s.cnt, 1);
        check("rst_rx_data", s.rd, 32'h34);
        check("rst_rx_flags", {s.fe[0], s.pe[0], s.ov[0]}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_buffered.md
Name: uart_rx_buffered

Overview:
Parametrised UART receiver with a synchronous receive FIFO, for the SOC's RXD path. It replaces the fixed 8N1, single-byte receive path. It adds:
- configurable data width, parity and stop bits
- mid-bit sampling with glitch rejection
- framing, parity and overrun error reporting
- buffering, so the CPU can drain a multi-byte command line such as "578\n" after the whole line has arrived.

Parameters:
CLKS_PER_BIT, 87, clk cycles per bit (10 MHz / 115200); must be ≥4
DATA_BITS, 8, data bits per frame (5..9), LSB first
PARITY, 0, 0=none, 1=even, 2=odd
STOP_BITS, 1, stop bits checked (1 or 2)
DEPTH, 16, FIFO entries; power of two, ≥2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
rxd  in  1  serial input, idle high, asynchronous to clk
rd_en  in  1  pop request; ignored when empty
rd_data  out  DATA_BITS  FIFO head (first-word fall-through)
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  $clog2(DEPTH)+1  current occupancy
frame_err  out  1  sticky: stop bit sampled low
parity_err  out  1  sticky: parity mismatch
overrun  out  1  sticky: frame completed while FIFO full
clr_err  in  1  one-cycle pulse; clears all three sticky flags
busy  out  1  high whenever the FSM is not IDLE

Behaviour:
- Reset values: all FSM state to IDLE; all counters 0; synchroniser flops 1; rd_data 0; empty=1; full=0; count=0; frame_err=0; parity_err=0; overrun=0; busy=0.
- rxd passes through a 2-flop synchroniser. All decisions use the synchronised value rxs. Input latency is 2 cycles.
- FSM states are IDLE, START, DATA, PARITY, STOP. One bit counter bit_cnt and one clock counter clk_cnt.
- IDLE: when rxs=0, go to START and clear clk_cnt.
- START: when clk_cnt reaches CLKS_PER_BIT/2-1, sample rxs.
  - rxs=1: glitch; return to IDLE with no flag and no push.
  - rxs=0: go to DATA; clear clk_cnt and bit_cnt.
- DATA: sample rxs each time clk_cnt reaches CLKS_PER_BIT-1 (the mid-bit point).
  - Shift the sample into the shift register, LSB first.
  - After DATA_BITS samples, go to PARITY if PARITY≠0, otherwise to STOP.
- PARITY: sample once at mid-bit. Compare against the XOR of the data bits, inverted for odd parity. Hold the mismatch result locally.
- STOP: sample STOP_BITS bits at mid-bit.
  - Any stop sample=0: set frame_err, discard the byte, return to IDLE. If rxs is still 0 at that point, stay in IDLE until rxs returns to 1 (break condition); no new frame starts during the break.
  - Parity mismatch with good stop bits: set parity_err and discard the byte.
  - Otherwise, push the byte on the cycle after the last stop sample.
  - Return to IDLE on the same cycle as the push or discard. The next start bit may begin immediately.
- Push when FIFO full and rd_en=0: drop the byte, set overrun, leave FIFO contents unchanged.
- Push and pop in the same cycle:
  - FIFO full: both occur; overrun is not set; count is unchanged.
  - FIFO empty: only the push occurs; rd_en is ignored.
- Pop: on rd_en & !empty, advance the read pointer. rd_data shows the next entry on the following cycle.
- count, empty and full are updated on the same edge as the push/pop. Pointers wrap modulo DEPTH; count distinguishes full from empty.
- Sticky flags: setting has priority over clr_err in the same cycle.
- Reset asserted mid-frame: the frame is abandoned and the FIFO is emptied. After reset releases, reception restarts only on a fresh high-to-low transition on rxs.

Decomposition:
- Shared package uart_pkg:
  - PARITY_NONE / PARITY_EVEN / PARITY_ODD constants
  - FSM state encodings
  - function clog2 for count width
- Sub-module sync_fifo (params WIDTH, DEPTH): registered pointers, FWFT output, count/empty/full.
  - Its push/pop rules are the ones above.
  - It must be reusable by a future buffered transmitter.

Test Plan:
1. Default parameters, send 0x35 with 8N1 at a bit period of 87 clk → after the stop-bit sample: empty=0, count=1, rd_data=0x35, no error flags.
2. Send 0x35, 0x37, 0x38, 0x0A back to back → count=4. Pulse rd_en four times; rd_data reads 0x35, 0x37, 0x38, 0x0A in order; then empty=1.
3. rxd low for 20 clk only → back to IDLE with busy=0, count=0, no flags. Drive a stop bit of 0 → frame_err=1, byte not pushed. Pulse clr_err → frame_err=0.
4. PARITY=1, send 0x31 (three ones) with parity bit 0 → parity_err=1, count=0. Same byte with parity bit 1 → rd_data=0x31.
5. DEPTH=4, send 5 bytes with no reads → full=1, overrun=1, FIFO holds bytes 1–4. Repeat with rd_en asserted on the 5th push cycle → overrun=0, count=4.
6. Assert reset mid-data-bit of 0x34 → all outputs at reset values. Then send 0x34 → received correctly.
